// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}; patterns are active-high.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Index 0 is the rightmost entry; codes 10..15 render as a dash.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high seven-segment pattern decoder.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_PATTERNS[nibble];
  end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed seven-segment driver: frame-synchronous value update,
// per-digit scan with inter-digit blanking, leading-zero suppression.
module bcd_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int Total_Nibbles      = 3,
  parameter int Refresh_Divider    = 1000,
  parameter int Blank_Cycles       = 2,
  parameter int Leading_Zero_Blank = 1,
  parameter int Active_Low         = 1
) (
  input  logic                          clk,
  input  logic                          sync_rst,
  input  logic                          clk_en,
  input  logic [Total_Nibbles-1:0][3:0] nibbles_in,
  input  logic [Total_Nibbles-1:0]      nibbles_valid,
  output logic [6:0]                    segments,
  output logic [Total_Nibbles-1:0]      digit_select,
  output logic                          frame_done,
  output logic                          update_ack
);

  localparam int MAX_CNT = (Refresh_Divider > Blank_Cycles) ? Refresh_Divider : Blank_Cycles;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (Total_Nibbles > 1) ? $clog2(Total_Nibbles) : 1;

  localparam logic [CNT_W-1:0]         ON_LAST    = CNT_W'(Refresh_Divider - 1);
  localparam logic [CNT_W-1:0]         BLANK_LAST = CNT_W'(Blank_Cycles - 1);
  localparam logic [IDX_W-1:0]         IDX_LAST   = IDX_W'(Total_Nibbles - 1);
  localparam logic [Total_Nibbles-1:0] DIG_ONE    = Total_Nibbles'(1'b1);
  localparam logic                     LZB_EN     = (Leading_Zero_Blank != 0);
  localparam logic [6:0]               SEG_POL    = (Active_Low != 0) ? 7'h7F : 7'h00;
  localparam logic [Total_Nibbles-1:0] DIG_POL    =
    (Active_Low != 0) ? {Total_Nibbles{1'b1}} : {Total_Nibbles{1'b0}};

  scan_state_e                     state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [Total_Nibbles-1:0][3:0]   display_q, display_d;
  logic [Total_Nibbles-1:0][3:0]   pending_q, pending_d;
  logic                            pending_full_q, pending_full_d;
  logic [6:0]                      segments_q, segments_d;
  logic [Total_Nibbles-1:0]        digit_select_q, digit_select_d;

  logic                            capture_s;
  logic                            frame_end_s;
  logic                            update_ack_s;
  logic [Total_Nibbles-1:0]        lz_blank_s;
  logic                            all_zero_s;
  logic [3:0]                      cur_nibble_s;
  logic [6:0]                      dec_seg_s;
  logic [6:0]                      seg_hi_s;
  logic [Total_Nibbles-1:0]        dig_hi_s;

  assign capture_s    = clk_en & (&nibbles_valid);
  assign cur_nibble_s = display_q[idx_q];

  bcd_to_seg7 u_dec (
    .nibble (cur_nibble_s),
    .seg    (dec_seg_s)
  );

  // Scan FSM; the frame closes on the last ON cycle of the most significant digit.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    frame_end_s = 1'b0;
    if (clk_en) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d     = ST_BLANK;
            cnt_d       = '0;
            idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            frame_end_s = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // A capture coinciding with frame end goes straight to the display.
  always_comb begin
    display_d      = display_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    update_ack_s   = 1'b0;
    if (frame_end_s) begin
      if (capture_s) begin
        display_d      = nibbles_in;
        pending_full_d = 1'b0;
        update_ack_s   = 1'b1;
      end else if (pending_full_q) begin
        display_d      = pending_q;
        pending_full_d = 1'b0;
        update_ack_s   = 1'b1;
      end else begin
        pending_full_d = 1'b0;
      end
    end else if (capture_s) begin
      pending_d      = nibbles_in;
      pending_full_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  always_comb begin
    lz_blank_s = '0;
    all_zero_s = 1'b1;
    for (int k = Total_Nibbles - 1; k >= 1; k--) begin
      all_zero_s    = all_zero_s & (display_q[k] == 4'd0);
      lz_blank_s[k] = all_zero_s & LZB_EN;
    end
  end

  always_comb begin
    seg_hi_s = SEG_OFF;
    dig_hi_s = '0;
    if ((state_q == ST_ON) && !lz_blank_s[idx_q]) begin
      seg_hi_s = dec_seg_s;
      dig_hi_s = DIG_ONE << idx_q;
    end else begin
      seg_hi_s = SEG_OFF;
    end
    segments_d     = seg_hi_s ^ SEG_POL;
    digit_select_d = dig_hi_s ^ DIG_POL;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q        <= ST_BLANK;
      idx_q          <= '0;
      cnt_q          <= '0;
      display_q      <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      segments_q     <= SEG_POL;
      digit_select_q <= DIG_POL;
    end else if (clk_en) begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      segments_q     <= segments_d;
      digit_select_q <= digit_select_d;
    end
  end

  assign segments     = segments_q;
  assign digit_select = digit_select_q;
  assign frame_done   = frame_end_s;
  assign update_ack   = update_ack_s;

endmodule
